// File: rtl/imm_ext_pipe.sv
// rtl/imm_ext_pipe.sv - pipelined immediate-extension unit with output register and skid buffer
//
// Extracts the low IMM_W bits of an instruction word and extends them to DATA_W
// bits according to a 2-bit mode. The result and its sideband tag are held in a
// one-deep output register backed by a one-entry skid buffer. This lets upstream
// and downstream stall independently while still sustaining one result per cycle.
//
// Ports:
//   clk        in   1        system clock, rising edge
//   reset_n    in   1        asynchronous active-low reset
//   in_valid   in   1        upstream presents a request
//   in_ready   out  1        unit can accept a request (registered, = !skid_valid)
//   in_instr   in   INSTR_W  instruction word; immediate is in_instr[IMM_W-1:0]
//   in_op      in   2        00 zero-ext, 01 sign-ext, 10 upper, 11 branch offset
//   in_tag     in   TAG_W    sideband tag, passed through unchanged
//   out_valid  out  1        out_imm/out_tag hold a result
//   out_ready  in   1        downstream accepts the result
//   out_imm    out  DATA_W   extended immediate
//   out_tag    out  TAG_W    tag matching out_imm

module imm_ext_pipe #(
    parameter int INSTR_W  = 32,
    parameter int IMM_W    = 16,
    parameter int DATA_W   = 32,
    parameter int BR_SHIFT = 2,
    parameter int TAG_W    = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [1:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_imm,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int EXT_W = DATA_W - IMM_W;

    localparam logic [1:0] OP_ZERO   = 2'b00;
    localparam logic [1:0] OP_SIGN   = 2'b01;
    localparam logic [1:0] OP_UPPER  = 2'b10;
    localparam logic [1:0] OP_BRANCH = 2'b11;

    // ------------------------------------------------------------------
    // Combinational extension of the incoming immediate field
    // ------------------------------------------------------------------
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] imm_zext;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_upper;
    logic [DATA_W-1:0] imm_branch;
    logic [DATA_W-1:0] ext_imm;

    assign imm        = in_instr[IMM_W-1:0];
    assign imm_zext   = {{EXT_W{1'b0}}, imm};
    assign imm_sext   = {{EXT_W{imm[IMM_W-1]}}, imm};
    assign imm_upper  = {imm, {EXT_W{1'b0}}};
    // Bits shifted past the top are simply lost; branch offsets never overflow-check.
    assign imm_branch = imm_sext << BR_SHIFT;

    always_comb begin
        ext_imm = imm_zext;
        case (in_op)
            OP_ZERO:   ext_imm = imm_zext;
            OP_SIGN:   ext_imm = imm_sext;
            OP_UPPER:  ext_imm = imm_upper;
            OP_BRANCH: ext_imm = imm_branch;
            default:   ext_imm = imm_zext;
        endcase
    end

    // Instruction bits above the immediate field are intentionally unused.
    generate
        if (INSTR_W > IMM_W) begin : g_unused_hi
            logic unused_instr_hi;
            assign unused_instr_hi = ^in_instr[INSTR_W-1:IMM_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output register + skid buffer
    //   (out_valid, skid_valid): EMPTY=(0,0), ONE=(1,0), FULL=(1,1)
    // ------------------------------------------------------------------
    logic              skid_valid;
    logic [DATA_W-1:0] skid_imm;
    logic [TAG_W-1:0]  skid_tag;
    logic              in_xfer;
    logic              out_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
            out_imm    <= '0;
            out_tag    <= '0;
            skid_imm   <= '0;
            skid_tag   <= '0;
        end else begin
            if (!out_valid) begin
                // EMPTY: skid is necessarily empty here, so new data goes straight out.
                if (in_xfer) begin
                    out_valid <= 1'b1;
                    out_imm   <= ext_imm;
                    out_tag   <= in_tag;
                end
            end else if (!skid_valid) begin
                // ONE
                if (in_xfer && out_xfer) begin
                    out_imm <= ext_imm;
                    out_tag <= in_tag;
                end else if (in_xfer) begin
                    // Downstream stalled: park the new result so out_* stays stable.
                    skid_valid <= 1'b1;
                    skid_imm   <= ext_imm;
                    skid_tag   <= in_tag;
                    in_ready   <= 1'b0;
                end else if (out_xfer) begin
                    out_valid <= 1'b0;
                end
            end else begin
                // FULL: in_ready is low, so only the output side can move.
                if (out_xfer) begin
                    out_imm    <= skid_imm;
                    out_tag    <= skid_tag;
                    skid_valid <= 1'b0;
                    in_ready   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb/tb_imm_ext_pipe.sv - directed self-checking bench for imm_ext_pipe
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    // default-parameter instance
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [1:0]  in_op = 2'b00;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_imm;
    logic [4:0]  out_tag;

    // 64-bit / 12-bit-immediate instance
    logic        w_in_valid = 1'b0;
    logic        w_in_ready;
    logic [31:0] w_in_instr = '0;
    logic [1:0]  w_in_op = 2'b00;
    logic [4:0]  w_in_tag = '0;
    logic        w_out_valid;
    logic        w_out_ready = 1'b1;
    logic [63:0] w_out_imm;
    logic [4:0]  w_out_tag;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imm_ext_pipe dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_tag(out_tag)
    );

    imm_ext_pipe #(.INSTR_W(32), .IMM_W(12), .DATA_W(64), .BR_SHIFT(1), .TAG_W(5)) dut64 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_instr(w_in_instr),
        .in_op(w_in_op), .in_tag(w_in_tag),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_imm(w_out_imm), .out_tag(w_out_tag)
    );

    task automatic check(input string name, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_tag;
        int next_tag;
        bit acc;

        // ---------------- reset state ----------------
        repeat (2) step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_imm",   64'(out_imm),   64'd0);
        check("rst_out_tag",   64'(out_tag),   64'd0);
        reset_n = 1'b1;

        // ---------------- modes ----------------
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h0000_8004;
        in_tag    = 5'd3;
        in_op = 2'b00; step();
        check("op00_valid", 64'(out_valid), 64'd1);
        check("op00_imm",   64'(out_imm),   64'h0000_8004);
        check("op00_tag",   64'(out_tag),   64'd3);
        in_op = 2'b01; step();
        check("op01_imm",   64'(out_imm),   64'hFFFF_8004);
        check("op01_tag",   64'(out_tag),   64'd3);
        in_op = 2'b10; step();
        check("op10_imm",   64'(out_imm),   64'h8004_0000);
        in_op = 2'b11; step();
        check("op11_imm",   64'(out_imm),   64'hFFFE_0010);
        check("op11_tag",   64'(out_tag),   64'd3);

        // ---------------- positive sign bit ----------------
        in_instr = 32'h1234_7FFF;
        in_op = 2'b01; step();
        check("pos_op01_imm", 64'(out_imm), 64'h0000_7FFF);
        in_op = 2'b11; step();
        check("pos_op11_imm", 64'(out_imm), 64'h0001_FFFC);
        in_valid = 1'b0; step();
        check("drain_valid", 64'(out_valid), 64'd0);

        // ---------------- parameter sweep (64-bit instance) ----------------
        w_in_valid = 1'b1;
        w_in_instr = 32'h0000_0800;
        w_in_op = 2'b01; step();
        check("w_op01_imm", w_out_imm, 64'hFFFF_FFFF_FFFF_F800);
        w_in_op = 2'b11; step();
        check("w_op11_imm", w_out_imm, 64'hFFFF_FFFF_FFFF_F000);
        w_in_op = 2'b10; step();
        check("w_op10_imm", w_out_imm, 64'h8000_0000_0000_0000);
        w_in_valid = 1'b0;

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        in_op     = 2'b00;
        in_valid  = 1'b1;
        in_tag    = 5'd1; in_instr = 32'd1; step();
        check("bp_ready_after1", 64'(in_ready), 64'd1);
        in_tag    = 5'd2; in_instr = 32'd2; step();
        check("bp_ready_after2", 64'(in_ready), 64'd0);
        check("bp_hold_tag_a",   64'(out_tag),  64'd1);
        in_tag    = 5'd3; in_instr = 32'd3; step();
        check("bp_hold_tag_b",   64'(out_tag),  64'd1);
        check("bp_hold_imm",     64'(out_imm),  64'd1);
        check("bp_still_full",   64'(in_ready), 64'd0);

        out_ready = 1'b1;
        exp_tag   = 1;
        next_tag  = 3;
        for (int cyc = 0; cyc < 30 && exp_tag <= 6; cyc++) begin
            if (out_valid && out_ready) begin
                check("bp_order_tag", 64'(out_tag), 64'(exp_tag));
                check("bp_order_imm", 64'(out_imm), 64'(exp_tag));
                exp_tag++;
            end
            acc = in_valid && in_ready;
            step();
            if (acc) begin
                next_tag++;
                in_tag   = 5'(next_tag);
                in_instr = 32'(next_tag);
                in_valid = (next_tag <= 6);
            end
        end
        check("bp_all_delivered", 64'(exp_tag), 64'd7);
        in_valid = 1'b0;
        step();
        check("bp_no_dup", 64'(out_valid), 64'd0);

        // ---------------- full throughput ----------------
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_tag   = 5'(i);
            in_instr = 32'(i + 100);
            step();
            check("tp_in_ready",  64'(in_ready),  64'd1);
            check("tp_out_valid", 64'(out_valid), 64'd1);
            check("tp_out_tag",   64'(out_tag),   64'(i));
            check("tp_out_imm",   64'(out_imm),   64'(i + 100));
        end
        in_valid = 1'b0;
        step();
        check("tp_drained", 64'(out_valid), 64'd0);

        // ---------------- reset while FULL ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 2'b00;
        in_instr  = 32'h0000_1234; in_tag = 5'd7; step();
        in_instr  = 32'h0000_5678; in_tag = 5'd8; step();
        check("rf_full", 64'(in_ready), 64'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("rf_out_valid", 64'(out_valid), 64'd0);
        check("rf_in_ready",  64'(in_ready),  64'd1);
        check("rf_out_imm",   64'(out_imm),   64'd0);
        check("rf_out_tag",   64'(out_tag),   64'd0);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        in_op     = 2'b01;
        in_instr  = 32'h0000_FFFF;
        in_tag    = 5'd9;
        step();
        check("rf_after_imm", 64'(out_imm), 64'hFFFF_FFFF);
        check("rf_after_tag", 64'(out_tag), 64'd9);
        in_valid = 1'b0;
        step();
        check("rf_no_stale", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
